shftr_unrot: RTL and testbench

- Iterative inverse of the negacyclic rotate network built from the existing rotate stages. The forward network rotates left by R and inverts every bit that wraps.
- This block rotates right by R and inverts every bit that wraps, so it restores the original word.
- Processes one power-of-two stage per clock, so a wide word needs no log-depth combinational mux tree. Sits on the read-back/decode side of the shifter datapath, behind a valid/ready handshake.

---
 rtl/shftr_unrot.sv | 90 +++++++++
 tb/tb_shftr_unrot.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shftr_unrot.sv
// shftr_unrot: iterative negacyclic un-rotate. The forward network rotates
// left by R and inverts every bit that wraps. This block rotates right by R,
// one power-of-two stage per clock, and inverts every bit that wraps back, so
// the original word is restored. A valid/ready handshake sits on both sides.
module shftr_unrot #(
  parameter  int DATA_W = 256,
  localparam int ROT_W  = (DATA_W == 1) ? 1 : $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ROT_W-1:0]  i_rot,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  // Stage counter only needs to index the ROT_W stages.
  localparam int CNT_W = (ROT_W == 1) ? 1 : $clog2(ROT_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                         state_q, state_d;
  logic [DATA_W-1:0]              work_q;
  logic [ROT_W-1:0]               amt_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [ROT_W-1:0][DATA_W-1:0]   cand;
  logic [DATA_W-1:0]              stage_d;
  logic                           last;

  // One candidate per stage: rotate right by 2^k, inverting the bits that
  // wrap from the bottom into the top. When 2^k covers the whole word
  // (only for DATA_W == 1) every bit wraps, i.e. plain inversion.
  for (genvar k = 0; k < ROT_W; k++) begin : g_stage
    localparam int D = 1 << k;
    if (D >= DATA_W) begin : g_full
      assign cand[k] = ~work_q;
    end else begin : g_part
      assign cand[k] = {~work_q[D-1:0], work_q[DATA_W-1:D]};
    end
  end

  // Current stage result: apply the candidate only if its amount bit is set.
  assign stage_d = amt_q[cnt_q] ? cand[cnt_q] : work_q;
  assign last    = (cnt_q == CNT_W'(ROT_W - 1));

  // State register plus work/amount/counter datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (i_valid) begin
          work_q <= i_data;
          amt_q  <= i_rot;
          cnt_q  <= '0;
        end
        SHIFT: begin
          work_q <= stage_d;
          if (!last) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state: fixed ROT_W shift cycles, then hold in DONE until drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = SHIFT;
      SHIFT:   if (last)    state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_data  = work_q;

endmodule

// File: tb/tb_shftr_unrot.sv
// Bench for shftr_unrot: three instances (DATA_W = 8, 256, 1) checked with a
// directed vector table, handshake/reset sequences and random round-trips
// against a plain-arithmetic negacyclic rotate model.
module tb_shftr_unrot;

  localparam int RW [3] = '{3, 8, 1};
  localparam int WW [3] = '{8, 256, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vin [3];
  logic       rin [3];
  logic [255:0] din [3];
  logic [7:0] rot [3];

  logic ov0, ov1, ov2, rd0, rd1, rd2, bz0, bz1, bz2;
  logic [7:0]   d0;
  logic [255:0] d1;
  logic [0:0]   d2;

  logic         ov  [3];
  logic         rdy [3];
  logic         bsy [3];
  logic [255:0] dout [3];

  assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
  assign rdy[0] = rd0; assign rdy[1] = rd1; assign rdy[2] = rd2;
  assign bsy[0] = bz0; assign bsy[1] = bz1; assign bsy[2] = bz2;
  assign dout[0] = {248'b0, d0};
  assign dout[1] = d1;
  assign dout[2] = {255'b0, d2};

  shftr_unrot #(.DATA_W(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[0]), .o_ready(rd0),
    .i_data(din[0][7:0]), .i_rot(rot[0][2:0]), .o_valid(ov0),
    .i_ready(rin[0]), .o_data(d0), .o_busy(bz0));

  shftr_unrot #(.DATA_W(256)) u256 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[1]), .o_ready(rd1),
    .i_data(din[1]), .i_rot(rot[1]), .o_valid(ov1),
    .i_ready(rin[1]), .o_data(d1), .o_busy(bz1));

  shftr_unrot #(.DATA_W(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[2]), .o_ready(rd2),
    .i_data(din[2][0:0]), .i_rot(rot[2][0:0]), .o_valid(ov2),
    .i_ready(rin[2]), .o_data(d2), .o_busy(bz2));

  int checks = 0;
  int errors = 0;

  // Handshake counters on the 256-bit instance.
  int acc1 = 0;
  int out1 = 0;
  always @(posedge clk) begin
    if (!rst && vin[1] && rdy[1]) acc1++;
    if (!rst && ov[1] && rin[1])  out1++;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Forward negacyclic rotate: left by r, wrapped bits inverted.
  function automatic logic [255:0] fwd(input logic [255:0] x, input int r, input int w);
    logic [255:0] y = '0;
    for (int i = 0; i < w; i++)
      y[i] = (i >= r) ? x[i - r] : ~x[i - r + w];
    return y;
  endfunction

  // Inverse: right by r, wrapped bits inverted.
  function automatic logic [255:0] unrot(input logic [255:0] y, input int r, input int w);
    logic [255:0] x = '0;
    for (int i = 0; i < w; i++)
      x[i] = (i + r < w) ? y[i + r] : ~y[i + r - w];
    return x;
  endfunction

  // One full transaction with i_ready held high; checks latency and that
  // o_valid is a single-cycle pulse followed by o_ready.
  task automatic xact(input int s, input logic [255:0] d, input logic [7:0] r,
                      output logic [255:0] got);
    int n;
    bit seen;
    @(negedge clk);
    chk("ready_idle", 256'(rdy[s]), 256'd1);
    din[s] = d; rot[s] = r; vin[s] = 1'b1; rin[s] = 1'b1;
    @(posedge clk);
    n = 0; seen = 0; got = '0;
    while (!seen && n < 40) begin
      @(negedge clk);
      vin[s] = 1'b0;
      n++;
      if (ov[s]) begin seen = 1; got = dout[s]; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout inst %0d: got no o_valid in 40 cycles, expected after %0d", s, RW[s] + 1);
    end else begin
      chk("latency", 256'(n), 256'(RW[s] + 1));
      @(negedge clk);
      chk("valid_drop", 256'(ov[s]), 256'd0);
      chk("ready_back", 256'(rdy[s]), 256'd1);
    end
  endtask

  typedef struct {
    int           s;
    logic [255:0] d;
    logic [7:0]   r;
    logic [255:0] e;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [255:0] got, x, y;
    int r, n;
    bit ghost;

    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; rin[i] = 1'b1; din[i] = '0; rot[i] = '0;
    end

    tbl[0] = '{0, 256'h08, 8'd3,   256'hE1};
    tbl[1] = '{0, 256'h01, 8'd1,   256'h00};
    tbl[2] = '{0, 256'hFF, 8'd4,   256'h0F};
    tbl[3] = '{0, 256'hA5, 8'd0,   256'hA5};
    tbl[4] = '{0, 256'h80, 8'd7,   256'hFF};
    tbl[5] = '{2, 256'h1,  8'd1,   256'h0};
    tbl[6] = '{2, 256'h1,  8'd0,   256'h1};
    tbl[7] = '{2, 256'h0,  8'd1,   256'h1};
    tbl[8] = '{1, 256'h1,  8'd255, ~256'h3};

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", 256'(ov[i]),  256'd0);
      chk("rst_ready", 256'(rdy[i]), 256'd1);
      chk("rst_busy",  256'(bsy[i]), 256'd0);
      chk("rst_data",  dout[i],      256'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int t = 0; t < 9; t++) begin
      xact(tbl[t].s, tbl[t].d, tbl[t].r, got);
      chk("table_data", got, tbl[t].e);
    end

    // Backpressure: hold in DONE, a competing i_valid must not be taken
    @(negedge clk);
    din[0] = 256'h08; rot[0] = 8'd3; vin[0] = 1'b1; rin[0] = 1'b0;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    din[0] = 256'h5A;
    while (!ov[0] && n < 40) begin @(negedge clk); n++; end
    chk("bp_reach_done", 256'(ov[0]), 256'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 256'(ov[0]),  256'd1);
      chk("bp_data",  dout[0],      256'hE1);
      chk("bp_ready", 256'(rdy[0]), 256'd0);
    end
    rin[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_drop_valid", 256'(ov[0]),  256'd0);
    chk("bp_idle_ready", 256'(rdy[0]), 256'd1);
    chk("bp_not_taken",  256'(bsy[0]), 256'd0);
    vin[0] = 1'b0;

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    din[0] = 256'hFF; rot[0] = 8'd5; vin[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin[0] = 1'b0;
    chk("pre_rst_busy", 256'(bsy[0]), 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 256'(ov[0]),  256'd0);
    chk("arst_busy",  256'(bsy[0]), 256'd0);
    chk("arst_data",  dout[0],      256'd0);
    chk("arst_ready", 256'(rdy[0]), 256'd1);
    @(negedge clk);
    rst = 1'b0;
    ghost = 0;
    repeat (12) begin @(negedge clk); if (ov[0]) ghost = 1; end
    chk("no_ghost_output", 256'(ghost), 256'd0);

    // Random round-trip on the 256-bit instance
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 8; k++) x[k*32 +: 32] = $urandom;
      r = $urandom_range(0, 255);
      y = fwd(x, r, 256);
      xact(1, y, 8'(r), got);
      chk("rt256_data", got, x);
    end

    // Random words on the narrow instances against the inverse model
    for (int t = 0; t < 60; t++) begin
      y = 256'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      xact(0, y, 8'(r), got);
      chk("rnd8_data", got, unrot(y, r, WW[0]));
      y = 256'($urandom_range(0, 1));
      r = $urandom_range(0, 1);
      xact(2, y, 8'(r), got);
      chk("rnd1_data", got, unrot(y, r, WW[2]));
    end

    @(negedge clk);
    chk("valid_count", 256'(out1), 256'(acc1));
    chk("accept_count", 256'(acc1), 256'd1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
